// File: rtl/ann_layer_sequencer.sv
// Cycle-level controller for the three-layer ANN datapath: image load, per-layer
// coefficient fetch with watchdog, accumulate sweep and output latch.
module ann_layer_sequencer #(
   parameter int IMAGE_SIZE   = 64,
   parameter int FIRST_LAYER  = 16,
   parameter int SECOND_LAYER = 4,
   parameter int COEF_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       abort,
   input  logic       coef_ack,
   output logic       coef_req,
   output logic [1:0] coef_layer,
   output logic [2:0] load_sel,
   output logic       reset_accum,
   output logic       acc_en,
   output logic [6:0] input_num,
   output logic       busy,
   output logic       done_processing,
   output logic       coef_error
);

   localparam int TW = $clog2(COEF_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_IMG,
      REQ_COEF,
      CLEAR,
      ACCUM,
      LATCH,
      DONE,
      ERROR
   } state_t;

   state_t        state, next_state;
   logic [1:0]    layer, next_layer;
   logic [6:0]    in_cnt, next_in_cnt;
   logic [TW-1:0] timer, next_timer;
   logic [6:0]    last_in;

   always_comb begin
      case (layer)
         2'd0:    last_in = 7'(IMAGE_SIZE - 1);
         2'd1:    last_in = 7'(FIRST_LAYER - 1);
         default: last_in = 7'(SECOND_LAYER - 1);
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         layer  <= 2'd0;
         in_cnt <= 7'd0;
         timer  <= '0;
      end else begin
         state  <= next_state;
         layer  <= next_layer;
         in_cnt <= next_in_cnt;
         timer  <= next_timer;
      end
   end

   // Outputs decode from registered state only; inputs affect only next-state values.
   always_comb begin
      next_state      = state;
      next_layer      = layer;
      next_in_cnt     = in_cnt;
      next_timer      = timer;
      coef_req        = 1'b0;
      coef_layer      = layer;
      load_sel        = 3'd0;
      reset_accum     = 1'b0;
      acc_en          = 1'b0;
      input_num       = in_cnt;
      busy            = 1'b1;
      done_processing = 1'b0;
      coef_error      = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state = LOAD_IMG;
               next_layer = 2'd0;
            end
         end
         LOAD_IMG: begin
            load_sel   = 3'd4;
            next_state = REQ_COEF;
         end
         REQ_COEF: begin
            coef_req = 1'b1;
            // A late ack still wins over the watchdog expiring in the same cycle.
            if (coef_ack) begin
               next_state  = CLEAR;
               next_timer  = '0;
               next_in_cnt = 7'd0;
            end else begin
               next_timer = timer + 1'b1;
               if (timer == TW'(COEF_TIMEOUT - 1))
                  next_state = ERROR;
            end
         end
         CLEAR: begin
            reset_accum = 1'b1;
            next_in_cnt = 7'd0;
            next_state  = ACCUM;
         end
         ACCUM: begin
            acc_en = 1'b1;
            if (in_cnt == last_in)
               next_state = LATCH;
            else
               next_in_cnt = in_cnt + 7'd1;
         end
         LATCH: begin
            load_sel = {1'b0, layer} + 3'd1;
            if (layer == 2'd2) begin
               next_state = DONE;
            end else begin
               next_layer = layer + 2'd1;
               next_state = REQ_COEF;
            end
         end
         DONE: begin
            done_processing = 1'b1;
            next_state      = IDLE;
            next_layer      = 2'd0;
            next_in_cnt     = 7'd0;
         end
         ERROR: begin
            busy       = 1'b0;
            coef_error = 1'b1;
            coef_layer = 2'd0;
            input_num  = 7'd0;
         end
         default: next_state = IDLE;
      endcase

      if (abort) begin
         next_state  = IDLE;
         next_layer  = 2'd0;
         next_in_cnt = 7'd0;
         next_timer  = '0;
      end
   end

endmodule

// File: doc/ann_layer_sequencer.md
Name: ann_layer_sequencer

Overview:
- Cycle-level controller for the three-layer ANN datapath (node array, pipeline register, coefficient source).
- Loads the image, then for each layer fetches coefficients over a req/ack handshake, clears the node accumulators, steps the input index, and latches node outputs back into the pipeline register.
- Includes a coefficient-fetch watchdog and a synchronous abort.
- Sits between the top-level image/weight loader and the node array / pipeline register mux.

Parameters:
IMAGE_SIZE, 64, layer-0 input count (pixels)
FIRST_LAYER, 16, layer-0 node count = layer-1 input count
SECOND_LAYER, 4, layer-1 node count = layer-2 input count
COEF_TIMEOUT, 255, max cycles coef_req may stay unacknowledged before error

Ports:
clk  in  1  clock
n_rst  in  1  reset
start  in  1  begin inference; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
coef_ack  in  1  coefficient source: weights for coef_layer valid
coef_req  out  1  request coefficients for coef_layer
coef_layer  out  2  layer being fetched/processed (0..2)
load_sel  out  3  pipeline register mux: 0 hold, 4 image, 1/2/3 node outputs after layer 0/1/2
reset_accum  out  1  clear node accumulators
acc_en  out  1  node accumulate enable
input_num  out  7  current input index to nodes
busy  out  1  high in any state except IDLE and ERROR
done_processing  out  1  one-cycle pulse at inference completion
coef_error  out  1  watchdog expired; sticky until abort

Behaviour:
- Reset n_rst is asynchronous and active-low; the clock is clk. Reset forces state IDLE, layer=0, input_num=0, timeout counter=0, and drives every output to 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- max_in(layer): layer 0 = IMAGE_SIZE, layer 1 = FIRST_LAYER, layer 2 = SECOND_LAYER.
- IDLE: outputs 0. If start=1, go to LOAD_IMG with layer=0. start in any other state is ignored.
- LOAD_IMG (1 cycle): load_sel=4. Next state REQ_COEF.
- REQ_COEF: coef_req=1 and coef_layer=layer. The timeout counter increments each cycle.
  - If coef_ack=1, go to CLEAR and zero the counter. Ack in the first REQ cycle is legal.
  - Else, if the counter reaches COEF_TIMEOUT, go to ERROR.
  - coef_ack in any other state is ignored.
- CLEAR (1 cycle): reset_accum=1, input_num=0. Next state ACCUM.
- ACCUM: acc_en=1. input_num increments by 1 each cycle starting from 0.
  - In the cycle where input_num == max_in(layer)-1, go to LATCH.
  - input_num never exceeds max_in-1 and never wraps.
- LATCH (1 cycle): load_sel=layer+1.
  - If layer==2, go to DONE.
  - Else increment layer and go to REQ_COEF.
- DONE (1 cycle): done_processing=1, busy=1. Next state IDLE, with layer and input_num cleared.
- ERROR: coef_error=1, busy=0, all other outputs 0. Exit only via abort or reset.
- abort=1 in any state:
  - Next state is IDLE.
  - Counters and layer are cleared; coef_error is cleared.
  - No load_sel, reset_accum or done pulse is issued.
  - abort has priority over start, coef_ack and timeout in the same cycle.
- Outside LOAD_IMG and LATCH, load_sel=0 (hold).
- Latency with immediate ack, LOAD_IMG as cycle 1:
  - REQ 2, CLEAR 3, ACCUM 4-67, LATCH 68.
  - REQ 69, CLEAR 70, ACCUM 71-86, LATCH 87.
  - REQ 88, CLEAR 89, ACCUM 90-93, LATCH 94.
  - DONE 95. Per layer: max_in+3 cycles.
- Ack arriving in the same cycle the timeout counter hits COEF_TIMEOUT counts as success (ack wins over timeout).

Test Plan:
- Reset then start=1 for one cycle, coef_ack tied high: load_sel=4 at cycle 1 and 1/2/3 at cycles 68/87/94. acc_en is high for exactly 64, 16 and 4 cycles. input_num ends at 63/15/3. done_processing pulses at cycle 95 only.
- coef_ack delayed 10 cycles on layer 1: coef_req held 10 cycles with coef_layer=1, done shifts to cycle 104, no coef_error.
- coef_ack held low on layer 0: ERROR entered after exactly COEF_TIMEOUT cycles (255). Then coef_error=1, busy=0, coef_req=0. abort=1 returns to IDLE with coef_error=0.
- Ack coincident with the final timeout count: the block proceeds to CLEAR and no error is flagged.
- abort asserted mid-ACCUM of layer 1 (input_num=7): next cycle is IDLE, input_num=0, with no LATCH or done. A subsequent start runs the full 95-cycle sequence.
- start pulsed during ACCUM, and n_rst asserted mid-layer-2: the start is ignored and the sequence is unchanged. The asynchronous reset zeros all outputs immediately, without waiting for a clock edge.
